fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of requester and FIFO write data.
REQ-002 SHALL have parameter BURST_LEN, default 4, maximum words accepted per grant; legal range 1..255.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the per-requester accepted-word counters.
REQ-004 fifoarb_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 fifoarb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 fifoarb_req0_i / fifoarb_req1_i  in  1 each  requester 0/1 has a word pending.
REQ-007 fifoarb_data0_i / fifoarb_data1_i  in  DATA_WIDTH each  requester 0/1 write data.
REQ-008 fifoarb_ack0_o / fifoarb_ack1_o  out  1 each  word of requester 0/1 accepted this cycle.
REQ-009 fifoarb_fullflag_i  in  1  FIFO full flag.
REQ-010 fifoarb_writeflag_o  out  1  FIFO write strobe.
REQ-011 fifoarb_writedata_o  out  DATA_WIDTH  FIFO write data.
REQ-012 fifoarb_grant_o  out  2  one-hot current owner: bit0 requester 0, bit1 requester 1; 00 idle.
REQ-013 fifoarb_count0_o / fifoarb_count1_o  out  CNT_WIDTH each  total words accepted from requester 0/1.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT0, GRANT1; fifoarb_grant_o decodes the state (IDLE=00, GRANT0=01, GRANT1=10).
REQ-015 SHALL hold a 1-bit priority pointer naming the requester favoured on the next arbitration.
REQ-016 Arbitration (evaluated in IDLE and at grant release): only one requesting -> grant it; both requesting -> grant the pointer requester; none -> IDLE.
REQ-017 IDLE SHALL never assert write or ack; first ack SHALL occur no earlier than the cycle after req is first sampled high.
REQ-018 In GRANTx, writeflag_o and ackx_o SHALL be asserted combinationally in the same cycle iff reqx_i=1 and fullflag_i=0; the other ack SHALL be 0.
REQ-019 writedata_o SHALL equal datax_i of the granted requester, and all-zero in IDLE.
REQ-020 A burst counter SHALL clear on entry to any GRANT state and increment only on accepted words; full-stall cycles SHALL not count.
REQ-021 Release SHALL occur at the clock edge where reqx_i=0, or where the BURST_LEN-th word is accepted; on release the pointer SHALL be set to the other requester and REQ-016 applied to the next state.
REQ-022 After a BURST_LEN-exhausted release with the other requester idle, the same requester SHALL be regranted directly (GRANTx -> GRANTx, counter cleared), without a cycle in IDLE.
REQ-023 While fullflag_i=1, the grant SHALL be held indefinitely with no write asserted; no word SHALL be dropped or duplicated.
REQ-024 countx_o SHALL increment by 1 per ackx_o cycle and wrap modulo 2^CNT_WIDTH.
REQ-025 With BURST_LEN=1, grants SHALL alternate every accepted word when both requesters request continuously.

Reset
REQ-026 On fifoarb_rst_i=1 at a clock edge: state IDLE, pointer 0, burst counter 0, count0_o=count1_o=0; outputs ack0/ack1/writeflag=0, grant=00, writedata=0 while in IDLE.
REQ-027 Reset mid-burst SHALL abandon the burst with no write in the reset cycle's following state; unaccepted requester words remain the requester's responsibility.

Structure
REQ-028 FSM state encodings and the grant one-hot codes SHALL live in a shared package, fifo_pkg, for reuse by the bench and FIFO read-side controllers.
REQ-029 The block SHALL be flat; the FIFO (fifo) is instantiated alongside it at the next level, not inside it.

Verification
REQ-030 Reset, then req0=1 alone for 6 cycles, full=0 -> no ack in the first cycle, ack0 on the next 5 cycles, grant stays 01 through a BURST_LEN regrant, count0=5.
REQ-031 req0=req1=1 continuously after reset, BURST_LEN=4 -> ack0 x4, then ack1 x4, then ack0 x4; no cycle without a write after the first grant.
REQ-032 GRANT1 with 2 words accepted, full=1 for 3 cycles, then full=0 -> no write during stall, grant held 10, exactly 2 more acks before release.
REQ-033 req1 drops after 1 word while req0=1 -> release at that edge, grant switches to 01 the next cycle, pointer=0 afterward.
REQ-034 CNT_WIDTH=4, 17 accepted words from requester 0 -> count0_o=1.
REQ-035 Assert reset during the 3rd word of a GRANT0 burst -> the next cycle grant=00, write=0, counts=0; re-arbitration favours requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared state / grant encodings for the FIFO write arbiter and its companions.
// The arbitration helper is reused by any controller that needs the same policy.
package fifo_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_REQ0 = 2'b01;
  localparam logic [1:0] GNT_REQ1 = 2'b10;

  // A lone requester wins outright; a tie goes to the requester named by ptr.
  function automatic logic [1:0] arbitrate(input logic r0, input logic r1, input logic ptr);
    if (r0 && r1) return ptr ? ST_GRANT1 : ST_GRANT0;
    else if (r0)  return ST_GRANT0;
    else if (r1)  return ST_GRANT1;
    else          return ST_IDLE;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter.sv
// Two-requester burst arbiter feeding a single FIFO write port.
// The owner streams up to BURST_LEN words per grant; full stalls hold the grant.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  fifoarb_clk_i,
  input  logic                  fifoarb_rst_i,
  input  logic                  fifoarb_req0_i,
  input  logic                  fifoarb_req1_i,
  input  logic [DATA_WIDTH-1:0] fifoarb_data0_i,
  input  logic [DATA_WIDTH-1:0] fifoarb_data1_i,
  output logic                  fifoarb_ack0_o,
  output logic                  fifoarb_ack1_o,
  input  logic                  fifoarb_fullflag_i,
  output logic                  fifoarb_writeflag_o,
  output logic [DATA_WIDTH-1:0] fifoarb_writedata_o,
  output logic [1:0]            fifoarb_grant_o,
  output logic [CNT_WIDTH-1:0]  fifoarb_count0_o,
  output logic [CNT_WIDTH-1:0]  fifoarb_count1_o
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

  logic [1:0]           state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [7:0]           bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] count0_q, count0_d;
  logic [CNT_WIDTH-1:0] count1_q, count1_d;

  logic own;
  logic own_req;
  logic acc;

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    bcnt_d              = bcnt_q;
    own                 = (state_q == ST_GRANT1);
    own_req             = own ? fifoarb_req1_i : fifoarb_req0_i;
    acc                 = 1'b0;
    fifoarb_ack0_o      = 1'b0;
    fifoarb_ack1_o      = 1'b0;
    fifoarb_writeflag_o = 1'b0;
    fifoarb_writedata_o = '0;
    fifoarb_grant_o     = GNT_NONE;
    case (state_q)
      ST_IDLE: begin
        state_d = arbitrate(fifoarb_req0_i, fifoarb_req1_i, ptr_q);
        bcnt_d  = 8'd0;
      end
      ST_GRANT0, ST_GRANT1: begin
        acc                 = own_req && !fifoarb_fullflag_i;
        fifoarb_ack0_o      = acc && !own;
        fifoarb_ack1_o      = acc && own;
        fifoarb_writeflag_o = acc;
        fifoarb_writedata_o = own ? fifoarb_data1_i : fifoarb_data0_i;
        fifoarb_grant_o     = own ? GNT_REQ1 : GNT_REQ0;
        // Release hands priority to the other side, then re-arbitrates on the
        // live requests, so an exhausted burst with no rival regrants in place.
        if (!own_req || (acc && bcnt_q == BURST_LAST)) begin
          ptr_d   = ~own;
          state_d = arbitrate(fifoarb_req0_i, fifoarb_req1_i, ~own);
          bcnt_d  = 8'd0;
        end else if (acc) begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = 8'd0;
      end
    endcase
  end

  assign count0_d = count0_q + {{(CNT_WIDTH-1){1'b0}}, fifoarb_ack0_o};
  assign count1_d = count1_q + {{(CNT_WIDTH-1){1'b0}}, fifoarb_ack1_o};

  always_ff @(posedge fifoarb_clk_i) begin
    if (fifoarb_rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      bcnt_q   <= 8'd0;
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      bcnt_q   <= bcnt_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end

  assign fifoarb_count0_o = count0_q;
  assign fifoarb_count1_o = count1_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: default-parameter arbiter plus a BURST_LEN=1 / CNT_WIDTH=4 copy on the same stimulus.
module tb_fifo_write_arbiter;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req0, req1, full;
  logic [31:0] data0, data1;
  logic        ack0, ack1, wr;
  logic [31:0] wdata;
  logic [1:0]  gnt;
  logic [15:0] cnt0, cnt1;
  logic        b_ack0, b_ack1, b_wr;
  logic [31:0] b_wdata;
  logic [1:0]  b_gnt;
  logic [3:0]  b_cnt0, b_cnt1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(32), .BURST_LEN(4), .CNT_WIDTH(16)) u_dut (
    .fifoarb_clk_i(clk), .fifoarb_rst_i(rst),
    .fifoarb_req0_i(req0), .fifoarb_req1_i(req1),
    .fifoarb_data0_i(data0), .fifoarb_data1_i(data1),
    .fifoarb_ack0_o(ack0), .fifoarb_ack1_o(ack1),
    .fifoarb_fullflag_i(full), .fifoarb_writeflag_o(wr),
    .fifoarb_writedata_o(wdata), .fifoarb_grant_o(gnt),
    .fifoarb_count0_o(cnt0), .fifoarb_count1_o(cnt1)
  );

  fifo_write_arbiter #(.DATA_WIDTH(32), .BURST_LEN(1), .CNT_WIDTH(4)) u_dut_b1 (
    .fifoarb_clk_i(clk), .fifoarb_rst_i(rst),
    .fifoarb_req0_i(req0), .fifoarb_req1_i(req1),
    .fifoarb_data0_i(data0), .fifoarb_data1_i(data1),
    .fifoarb_ack0_o(b_ack0), .fifoarb_ack1_o(b_ack1),
    .fifoarb_fullflag_i(full), .fifoarb_writeflag_o(b_wr),
    .fifoarb_writedata_o(b_wdata), .fifoarb_grant_o(b_gnt),
    .fifoarb_count0_o(b_cnt0), .fifoarb_count1_o(b_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_n);
  endtask

  // Drive one cycle's inputs at the falling edge, settle, leave outputs ready to check.
  task automatic cyc(input logic r0, input logic r1, input logic f);
    @(negedge clk);
    cyc_n++;
    req0  = r0;
    req1  = r1;
    full  = f;
    data0 = 32'h1000_0000 | 32'(cyc_n);
    data1 = 32'h2000_0000 | 32'(cyc_n);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Expect the default instance to be writing owner o's word this cycle.
  task automatic exp_write(input string tag, input int o);
    chk({tag, "_ack0"},  32'(ack0), (o == 0) ? 32'd1 : 32'd0);
    chk({tag, "_ack1"},  32'(ack1), (o == 1) ? 32'd1 : 32'd0);
    chk({tag, "_wr"},    32'(wr), 32'd1);
    chk({tag, "_wdata"}, wdata, (o == 0) ? data0 : data1);
    chk({tag, "_gnt"},   32'(gnt), (o == 0) ? 32'd1 : 32'd2);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0; data0 = '0; data1 = '0;

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_wdata", wdata, 32'd0);

    // Lone requester 0 for 6 cycles: idle first, then 5 words across a regrant
    cyc(1, 0, 0);
    chk("solo_idle_ack0", 32'(ack0), 32'd0);
    chk("solo_idle_wr", 32'(wr), 32'd0);
    chk("solo_idle_wdata", wdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      exp_write("solo", 0);
    end
    cyc(0, 0, 0);
    chk("solo_drop_ack0", 32'(ack0), 32'd0);
    chk("solo_drop_gnt", 32'(gnt), 32'd1);
    chk("solo_cnt0", 32'(cnt0), 32'd5);
    cyc(0, 0, 0);
    chk("solo_rel_gnt", 32'(gnt), 32'd0);

    // Both requesting: bursts of 4 alternate; the BURST_LEN=1 copy alternates per word
    do_reset();
    cyc(1, 1, 0);
    chk("both_idle_gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0);
      exp_write("both", (i >= 4 && i < 8) ? 1 : 0);
      chk("b1_alt_ack0", 32'(b_ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("b1_alt_ack1", 32'(b_ack1), (i % 2 == 1) ? 32'd1 : 32'd0);
    end

    // Now in GRANT1: 2 words, 3-cycle full stall, then exactly 2 more before release
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0);
      exp_write("pre_stall", 1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1);
      chk("stall_wr", 32'(wr), 32'd0);
      chk("stall_ack1", 32'(ack1), 32'd0);
      chk("stall_gnt", 32'(gnt), 32'd2);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0);
      exp_write("post_stall", 1);
    end
    cyc(1, 1, 0);
    exp_write("after_rel", 0);
    chk("stall_cnt0", 32'(cnt0), 32'd8);
    chk("stall_cnt1", 32'(cnt1), 32'd8);

    // Requester 1 drops after one word while requester 0 waits
    do_reset();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    exp_write("drop_w1", 1);
    cyc(1, 0, 0);
    chk("drop_gnt", 32'(gnt), 32'd2);
    chk("drop_wr", 32'(wr), 32'd0);
    cyc(1, 1, 0);
    exp_write("drop_sw", 0);

    // Reset on the 3rd word of a GRANT0 burst
    do_reset();
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    exp_write("mr_w1", 0);
    cyc(1, 1, 0);
    exp_write("mr_w2", 0);
    cyc(1, 1, 0);
    rst = 1'b1;
    #1;
    chk("mr_w3_ack0", 32'(ack0), 32'd1);
    cyc(1, 1, 0);
    rst = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_wr", 32'(wr), 32'd0);
    chk("mr_cnt0", 32'(cnt0), 32'd0);
    chk("mr_cnt1", 32'(cnt1), 32'd0);
    cyc(1, 1, 0);
    exp_write("mr_regrant", 0);

    // 17 words from requester 0: 4-bit counter wraps to 1
    do_reset();
    cyc(1, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 0);
      chk("wrap_b1_ack0", 32'(b_ack0), 32'd1);
    end
    cyc(0, 0, 0);
    chk("wrap_b1_cnt0", 32'(b_cnt0), 32'd1);
    chk("wrap_cnt0", 32'(cnt0), 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
